// File: rtl/c_reg_result_drain_if.sv
// rtl/c_reg_result_drain_if.sv - control-register, result-buffer and TX byte-stream signals of the drain block
interface c_reg_result_drain_if;
  logic [31:0] status;
  logic [31:0] result_bytes;
  logic        cr_we;
  logic [31:0] cr_addr;
  logic [31:0] cr_din;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  modport master (
    input  status, result_bytes, mem_rdata, tx_ready,
    output cr_we, cr_addr, cr_din, mem_re, mem_addr, tx_data, tx_valid, busy
  );

  modport slave (
    output status, result_bytes, mem_rdata, tx_ready,
    input  cr_we, cr_addr, cr_din, mem_re, mem_addr, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/c_reg_result_drain.sv
// rtl/c_reg_result_drain.sv - drains the result buffer to the TX byte stream when the CPU flags DONE
module c_reg_result_drain #(
  parameter logic [31:0] RESULT_BASE = 32'h0000_0000,
  parameter int unsigned MAX_BYTES   = 4096
) (
  input logic                   clk,
  input logic                   rst,
  c_reg_result_drain_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FETCH, S_WAIT, S_SEND, S_FIN
  } state_t;

  localparam logic [31:0] MAX_CNT = 32'(MAX_BYTES);

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [31:0] idx;
  logic [31:0] word_buf;
  logic [31:0] cnt_clamp;
  logic [31:0] idx_inc;

  assign cnt_clamp = (bus.result_bytes > MAX_CNT) ? MAX_CNT : bus.result_bytes;
  assign idx_inc   = idx + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      word_buf <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_START: begin
          cnt <= cnt_clamp;
          idx <= '0;
        end
        S_WAIT:  word_buf <= bus.mem_rdata;
        S_SEND:  if (bus.tx_ready) idx <= idx_inc;
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the state alone so that tx_data is held stable under backpressure.
  always_comb begin
    state_nxt    = state;
    bus.cr_we    = 1'b0;
    bus.cr_addr  = '0;
    bus.cr_din   = '0;
    bus.mem_re   = 1'b0;
    bus.mem_addr = '0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // bit1 (DRAINING) still set means the previous drain was never acknowledged
        if (bus.status[0] && !bus.status[1]) state_nxt = S_START;
      end
      S_START: begin
        bus.cr_we  = 1'b1;
        bus.cr_din = bus.status | 32'h2;
        state_nxt  = (cnt_clamp == '0) ? S_FIN : S_FETCH;
      end
      S_FETCH: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = RESULT_BASE + {2'b00, idx[31:2]};
        state_nxt    = S_WAIT;
      end
      S_WAIT: state_nxt = S_SEND;
      S_SEND: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = word_buf[{idx[1:0], 3'b000} +: 8];
        if (bus.tx_ready) begin
          if (idx_inc == cnt)             state_nxt = S_FIN;
          else if (idx_inc[1:0] == 2'b00) state_nxt = S_FETCH;
        end
      end
      S_FIN: begin
        bus.cr_we  = 1'b1;
        bus.cr_din = 32'h4;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_c_reg_result_drain.sv
// tb/tb_c_reg_result_drain.sv - bench for c_reg_result_drain
module tb_c_reg_result_drain;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int MAXB = 4096;

  logic clk;
  logic rst;
  c_reg_result_drain_if bus ();

  c_reg_result_drain #(.RESULT_BASE(BASE), .MAX_BYTES(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] mem [0:1023];

  logic [7:0]  tx_log [$];
  logic [31:0] re_log [$];
  logic [31:0] we_log [$];
  int          we_cyc [$];
  int first_valid_cyc, last_hs_cyc, busy_cycles, bad_addr_we;

  logic        p_hs, p_re, p_we, p_valid, busy_now;
  logic [7:0]  p_data;
  logic [31:0] p_addr, p_din, p_caddr;

  int   stall_trig = -1;
  int   stall_len  = 0;
  int   stall_left = 0;
  logic [7:0] stall_exp;
  bit   rand_ready = 0;
  bit   force_low  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return (off < 32'd1024) ? mem[off[9:0]] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    w = mem[i / 4];
    return 8'(w >> (8 * (i % 4)));
  endfunction

  task automatic clear_logs();
    tx_log.delete(); re_log.delete(); we_log.delete(); we_cyc.delete();
    first_valid_cyc = -1; last_hs_cyc = -1; busy_cycles = 0; bad_addr_we = 0;
  endtask

  // One clock: fold in last cycle's events, drive inputs, then sample outputs mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (p_hs) begin tx_log.push_back(p_data); last_hs_cyc = cyc - 1; end
    if (p_re) re_log.push_back(p_addr);
    if (p_we) begin
      we_log.push_back(p_din);
      we_cyc.push_back(cyc - 1);
      if (p_caddr[1:0] == 2'b00) bus.status = p_din;
      else bad_addr_we++;
    end
    bus.mem_rdata = p_re ? mem_word(p_addr) : $urandom;
    if (stall_trig >= 0 && bus.tx_valid && tx_log.size() == stall_trig) begin
      stall_left = stall_len;
      stall_trig = -1;
    end
    if (force_low) bus.tx_ready = 1'b0;
    else if (stall_left > 0) begin
      bus.tx_ready = 1'b0;
      stall_left--;
      chk("stall_valid", bus.tx_valid, 1'b1);
      chk("stall_data", bus.tx_data, stall_exp);
    end else bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    p_valid  = bus.tx_valid;
    p_hs     = bus.tx_valid && bus.tx_ready;
    p_data   = bus.tx_data;
    p_re     = bus.mem_re;
    p_addr   = bus.mem_addr;
    p_we     = bus.cr_we;
    p_din    = bus.cr_din;
    p_caddr  = bus.cr_addr;
    busy_now = bus.busy;
    if (busy_now) busy_cycles++;
    if (p_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
  endtask

  task automatic do_drain(input string tag, input logic [31:0] st, input logic [31:0] rb, input int budget);
    int k, start_cyc, n, bad;
    bit seen;
    clear_logs();
    bus.status = st;
    bus.result_bytes = rb;
    start_cyc = cyc;
    seen = 0;
    k = 0;
    while (k < budget) begin
      tick();
      k++;
      if (busy_now) seen = 1;
      else if (seen) break;
    end
    chk({tag, "_finished"}, (k < budget), 1'b1);
    n = (rb > MAXB) ? MAXB : int'(rb);
    chk({tag, "_nbytes"}, tx_log.size(), n);
    bad = 0;
    for (int i = 0; i < tx_log.size() && i < n; i++)
      if (tx_log[i] !== exp_byte(i)) bad++;
    chk({tag, "_byte_errs"}, bad, 0);
    chk({tag, "_nreads"}, re_log.size(), (n + 3) / 4);
    bad = 0;
    foreach (re_log[i]) if (re_log[i] !== BASE + i) bad++;
    chk({tag, "_addr_errs"}, bad, 0);
    if (n > 0) begin
      chk({tag, "_last_addr"}, re_log[$], BASE + (n - 1) / 4);
      chk({tag, "_latency"}, first_valid_cyc - start_cyc, 4);
    end
    chk({tag, "_nwrites"}, we_log.size(), 2);
    chk({tag, "_bad_addr"}, bad_addr_we, 0);
    if (we_log.size() == 2) begin
      chk({tag, "_start_din"}, we_log[0], st | 32'h2);
      chk({tag, "_fin_din"}, we_log[1], 32'h4);
      if (n > 0) chk({tag, "_fin_after_hs"}, we_cyc[1], last_hs_cyc + 1);
      else       chk({tag, "_fin_after_start"}, we_cyc[1], we_cyc[0] + 1);
    end
    if (n == 0) begin
      chk({tag, "_busy_cycles"}, busy_cycles, 2);
      chk({tag, "_no_valid"}, first_valid_cyc, -1);
    end
    chk({tag, "_status_after"}, bus.status, 32'h4);
  endtask

  initial begin
    int n, k;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    p_hs = 0; p_re = 0; p_we = 0; p_valid = 0;
    p_data = '0; p_addr = '0; p_din = '0; p_caddr = '0; busy_now = 0;
    rst = 1'b0;
    bus.status = '0;
    bus.result_bytes = '0;
    bus.mem_rdata = '0;
    bus.tx_ready = 1'b1;
    clear_logs();

    repeat (3) tick();
    chk("rst_cr_we", p_we, 1'b0);
    chk("rst_cr_addr", p_caddr, 32'h0);
    chk("rst_cr_din", p_din, 32'h0);
    chk("rst_mem_re", p_re, 1'b0);
    chk("rst_mem_addr", p_addr, 32'h0);
    chk("rst_tx_valid", p_valid, 1'b0);
    chk("rst_tx_data", p_data, 8'h00);
    chk("rst_busy", busy_now, 1'b0);
    rst = 1'b1;
    repeat (2) tick();

    do_drain("zero", 32'h1, 32'h0, 40);

    mem[0] = 32'h4433_2211;
    mem[1] = 32'h0000_6655;
    do_drain("six", 32'h1, 32'd6, 60);
    if (tx_log.size() == 6) chk("six_byte5", tx_log[5], 8'h66);

    stall_trig = 1; stall_len = 5; stall_exp = 8'h22;
    do_drain("stall", 32'h1, 32'd6, 80);
    chk("stall_consumed", stall_left, 0);

    rand_ready = 1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      n = $urandom_range(1, 40);
      do_drain("rand", 32'h1 | ($urandom & 32'hFFFF_FFF8), 32'(n), 400);
    end
    rand_ready = 0;

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    do_drain("clamp", 32'h1, 32'hFFFF_FFFF, 8000);

    clear_logs();
    bus.status = 32'h3;
    bus.result_bytes = 32'd5;
    repeat (10) tick();
    chk("guard_busy", busy_cycles, 0);
    chk("guard_writes", we_log.size(), 0);
    do_drain("guard_go", 32'h1, 32'd5, 60);

    mem[0] = 32'h4433_2211;
    mem[1] = 32'h0000_6655;
    clear_logs();
    bus.status = 32'h1;
    bus.result_bytes = 32'd6;
    k = 0;
    while (!p_hs && k < 20) begin tick(); k++; end
    chk("rstmid_reached_send", p_hs, 1'b1);
    force_low = 1;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rstmid_tx_valid", p_valid, 1'b0);
    chk("rstmid_busy", busy_now, 1'b0);
    chk("rstmid_cr_we", p_we, 1'b0);
    force_low = 0;
    busy_cycles = 0;
    repeat (10) tick();
    chk("rstmid_bytes", tx_log.size(), 1);
    chk("rstmid_writes", we_log.size(), 1);
    chk("rstmid_no_restart", busy_cycles, 0);
    chk("rstmid_status", bus.status, 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
